// File: rtl/uart_txq_pkg.sv
// uart_txq_pkg: shared types and defaults for the UART transmit queue.
//   UART_BYTE_W  - byte width carried through the queue
//   TXQ_DEPTH    - default FIFO depth (power of 2)
//   TXQ_BUSY_TMO - default cycles to wait for the transmitter to go busy
//   txq_state_e  - launch sequencer states
package uart_txq_pkg;
    localparam int UART_BYTE_W  = 8;
    localparam int TXQ_DEPTH    = 16;
    localparam int TXQ_BUSY_TMO = 7;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } txq_state_e;
endpackage

// File: rtl/uart_txq_fifo.sv
// uart_txq_fifo: circular byte buffer with separate occupancy count.
//   sys_clk_i / sys_rst_l_i - clock, synchronous active-low reset
//   wr_en_i / wr_data_i     - push request and byte
//   flush_i                 - drop all queued bytes (beats push and pop)
//   pop_i                   - consume head_o (only issued when not empty)
//   head_o                  - oldest queued byte
//   full_o / empty_o        - occupancy flags
//   count_o                 - bytes queued, 0..DEPTH
//   overflow_o              - one-cycle pulse for a rejected push
module uart_txq_fifo
    import uart_txq_pkg::*;
#(
    parameter int DEPTH = TXQ_DEPTH,
    parameter int AW    = 4
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_l_i,
    input  logic                   wr_en_i,
    input  logic [UART_BYTE_W-1:0] wr_data_i,
    input  logic                   flush_i,
    input  logic                   pop_i,
    output logic [UART_BYTE_W-1:0] head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [AW:0]            count_o,
    output logic                   overflow_o
);
    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q;
    logic                   ovf_q;
    logic                   push;
    // A full queue still takes a byte when the head leaves in the same cycle.
    assign push       = wr_en_i && (!full_o || pop_i) && !flush_i;
    assign head_o     = mem_q[rd_ptr_q];
    assign full_o     = count_q == (AW+1)'(DEPTH);
    assign empty_o    = count_q == '0;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_l_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop_i);
            count_q  <= count_q + (AW+1)'(push) - (AW+1)'(pop_i);
        end
        ovf_q <= sys_rst_l_i && wr_en_i && full_o && !pop_i;
    end
    always_ff @(posedge sys_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue that launches frames into the UART transmitter.
//   sys_clk, sys_rst_l       - clock, synchronous active-low reset
//   wr_en, wr_data, flush    - host push / discard-queue controls
//   full, empty, count       - queue occupancy
//   overflow                 - pulse: push rejected because queue full
//   launch_err               - pulse: transmitter never went busy after launch
//   xmitH, xmit_dataH        - launch pulse and byte to the transmitter
//   xmit_doneH               - transmitter idle/done level
// Optional UART_TXQ_STATS_EN adds saturating sent_cnt, drop_cnt, err_cnt.
module uart_tx_queue
    import uart_txq_pkg::*;
#(
    parameter int DEPTH    = TXQ_DEPTH,
    parameter int AW       = 4,
    parameter int BUSY_TMO = TXQ_BUSY_TMO
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_l,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count,
    output logic                   overflow,
    output logic                   launch_err,
    output logic                   xmitH,
    output logic [UART_BYTE_W-1:0] xmit_dataH,
    input  logic                   xmit_doneH
`ifdef UART_TXQ_STATS_EN
    ,
    output logic [15:0]            sent_cnt,
    output logic [15:0]            drop_cnt,
    output logic [7:0]             err_cnt
`endif
);
    localparam int TW = (BUSY_TMO < 2) ? 1 : $clog2(BUSY_TMO + 1);
    txq_state_e             state_q;
    logic [TW-1:0]          tmo_q;
    logic [UART_BYTE_W-1:0] head;
    logic                   pop;
    assign pop = (state_q == IDLE) && !empty && xmit_doneH && !flush;
    uart_txq_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .sys_clk_i  (sys_clk),
        .sys_rst_l_i(sys_rst_l),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .flush_i    (flush),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow)
    );
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            xmitH      <= 1'b0;
            xmit_dataH <= '0;
            launch_err <= 1'b0;
        end else begin
            xmitH      <= 1'b0;
            launch_err <= 1'b0;
            case (state_q)
                IDLE: if (pop) begin
                    xmit_dataH <= head;
                    xmitH      <= 1'b1;
                    state_q    <= ARMED;
                end
                ARMED: begin
                    tmo_q   <= TW'(BUSY_TMO);
                    state_q <= WAIT_BUSY;
                end
                // Trip when the decrement would reach zero; the byte is lost.
                WAIT_BUSY: if (!xmit_doneH) state_q <= WAIT_DONE;
                    else if (tmo_q <= TW'(1)) begin
                        launch_err <= 1'b1;
                        state_q    <= IDLE;
                    end else tmo_q <= tmo_q - TW'(1);
                WAIT_DONE: if (xmit_doneH) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef UART_TXQ_STATS_EN
    logic [17:0] drop_sum;
    // A flush discards whatever is queued at that edge.
    assign drop_sum = {2'b00, drop_cnt} + 18'(overflow) + (flush ? 18'(count) : 18'd0);
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            sent_cnt <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (xmitH && sent_cnt != '1) sent_cnt <= sent_cnt + 16'd1;
            if (launch_err && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
            drop_cnt <= (drop_sum > 18'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench with a behavioural transmitter model.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    logic       sys_clk = 1'b0;
    logic       sys_rst_l = 1'b0;
    logic       wr_en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, launch_err, xmitH, xmit_doneH;
    logic [4:0] count;
    logic [7:0] xmit_dataH;
`ifdef UART_TXQ_STATS_EN
    logic [15:0] sent_cnt, drop_cnt;
    logic [7:0]  err_cnt;
`endif
    always #5 sys_clk = ~sys_clk;

    uart_tx_queue #(.DEPTH(16), .AW(4), .BUSY_TMO(7)) dut (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .wr_en(wr_en), .wr_data(wr_data),
        .flush(flush), .full(full), .empty(empty), .count(count), .overflow(overflow),
        .launch_err(launch_err), .xmitH(xmitH), .xmit_dataH(xmit_dataH),
        .xmit_doneH(xmit_doneH)
`ifdef UART_TXQ_STATS_EN
        , .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
`endif
    );

    // Transmitter model: goes busy two cycles after a launch, stays busy frame_len cycles.
    int   frame_len = 20;
    bit   never_busy = 1'b0;
    bit   hold_busy = 1'b0;
    logic done_r = 1'b1;
    int   dly = 0;
    int   bcnt = 0;
    assign xmit_doneH = done_r & ~hold_busy;
    always @(posedge sys_clk) begin
        if (xmitH && !never_busy) dly <= 1;
        else if (dly == 1) begin
            dly    <= 0;
            done_r <= 1'b0;
            bcnt   <= frame_len;
        end else if (bcnt > 1) bcnt <= bcnt - 1;
        else if (bcnt == 1) begin
            bcnt   <= 0;
            done_r <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected bytes queued at write time, popped when the DUT launches.
    logic [7:0] exp_q[$];
    logic [7:0] last_data = 8'h00;
    logic       m_dn = 1'b1;
    int         n_launch = 0;
    int         l_cyc[$];
    int         r_cyc[$];
    logic [7:0] l_dat[$];
    always @(posedge sys_clk) begin
        logic       we, fl, rs, popped, ovf_e;
        logic [7:0] wd;
        int         pre;
        we = wr_en; wd = wr_data; fl = flush; rs = sys_rst_l;
        #1;
        if (!rs) begin
            exp_q.delete();
            last_data = 8'h00;
            chk("rst_xmitH", xmitH, 0);
            chk("rst_data", xmit_dataH, 0);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_launch_err", launch_err, 0);
        end else begin
            pre = exp_q.size();
            popped = xmitH;
            if (popped) begin
                n_launch++;
                l_cyc.push_back(cyc);
                l_dat.push_back(xmit_dataH);
                chk("launch_while_done", m_dn, 1);
                chk("launch_not_in_flush", fl, 0);
                if (pre == 0) chk("launch_spurious", xmitH, 0);
                else chk("launch_data", xmit_dataH, exp_q.pop_front());
                last_data = xmit_dataH;
            end else chk("data_hold", xmit_dataH, last_data);
            ovf_e = we && pre == DEPTH && !popped;
            if (fl) exp_q.delete();
            else if (we && !ovf_e) exp_q.push_back(wd);
            chk("count", count, exp_q.size());
            chk("overflow", overflow, ovf_e);
            chk("full", full, exp_q.size() == DEPTH);
            chk("empty", empty, exp_q.size() == 0);
        end
        if (xmit_doneH && !m_dn) r_cyc.push_back(cyc);
        m_dn = xmit_doneH;
    end

    task automatic step();
        @(negedge sys_clk);
    endtask
    task automatic drive(input logic we, input logic [7:0] d, input logic fl);
        wr_en = we; wr_data = d; flush = fl;
    endtask
    function automatic logic sig(input int w);
        return (w == 0) ? xmitH : (w == 1) ? xmit_doneH : launch_err;
    endfunction
    task automatic wait_sig(input string nm, input int w, input logic v, input int max);
        int n = 0;
        while (sig(w) !== v && n < max) begin step(); n++; end
        chk(nm, sig(w), v);
    endtask
    task automatic drain(input int max);
        int st = 0;
        int n = 0;
        while (st < 6 && n < max) begin
            step(); n++;
            st = (count == 0 && xmit_doneH && !xmitH) ? st + 1 : 0;
        end
        chk("drain_timeout", st, 6);
    endtask

    initial begin
        #300000;
        n_err++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int l;
        repeat (2) step();
        sys_rst_l = 1'b1;
        step();
        // single byte latency
        frame_len = 20;
        drive(1, 8'hA5, 0);
        step(); drive(0, 0, 0);
        chk("t1_empty_c1", empty, 0);
        chk("t1_xmitH_c1", xmitH, 0);
        step();
        chk("t1_xmitH_c2", xmitH, 1);
        chk("t1_data_c2", xmit_dataH, 8'hA5);
        chk("t1_count_c2", count, 0);
        step();
        chk("t1_xmitH_c3", xmitH, 0);
        drain(200);
        // burst of five, back-to-back frames
        frame_len = 160;
        l_cyc.delete(); r_cyc.delete(); l_dat.delete();
        for (int i = 1; i <= 5; i++) begin step(); drive(1, 8'(i), 0); end
        step(); drive(0, 0, 0);
        drain(2000);
        chk("t2_launches", l_cyc.size(), 5);
        for (int i = 0; i < l_dat.size() && i < 5; i++) chk("t2_order", l_dat[i], i + 1);
        for (int i = 1; i < l_cyc.size() && i <= r_cyc.size(); i++)
            chk("t2_gap", l_cyc[i] - r_cyc[i-1], 2);
        // fill while busy, overflow, then push+pop when full
        frame_len = 400;
        step(); drive(1, 8'h10, 0);
        step(); drive(0, 0, 0);
        wait_sig("t3_busy", 1, 1'b0, 20);
        for (int i = 0; i < 16; i++) begin step(); drive(1, 8'h20 + 8'(i), 0); end
        step(); drive(1, 8'hFF, 0);
        chk("t3_full", full, 1);
        chk("t3_count16", count, 16);
        step(); drive(0, 0, 0);
        chk("t3_overflow", overflow, 1);
        chk("t3_count_kept", count, 16);
        step();
        chk("t3_overflow_pulse", overflow, 0);
        wait_sig("t3_done_rise", 1, 1'b1, 600);
        step(); drive(1, 8'hEE, 0);
        step(); drive(0, 0, 0);
        frame_len = 10;
        chk("t3_pp_launch", xmitH, 1);
        chk("t3_pp_data", xmit_dataH, 8'h20);
        chk("t3_pp_no_ovf", overflow, 0);
        chk("t3_pp_count", count, 16);
        drain(3000);
        // transmitter never goes busy
        never_busy = 1'b1;
        step(); drive(1, 8'h31, 0);
        step(); drive(1, 8'h32, 0);
        step(); drive(0, 0, 0);
        wait_sig("t4_launch", 0, 1'b1, 10);
        for (int k = 1; k <= 8; k++) begin step(); chk("t4_err_timing", launch_err, k == 8); end
        step();
        chk("t4_err_pulse", launch_err, 0);
        chk("t4_next_launch", xmitH, 1);
        chk("t4_next_data", xmit_dataH, 8'h32);
        wait_sig("t4_err2", 2, 1'b1, 20);
        step();
        never_busy = 1'b0;
        drain(200);
        // flush mid-frame
        frame_len = 60;
        step(); drive(1, 8'h40, 0);
        step(); drive(0, 0, 0);
        wait_sig("t5_busy", 1, 1'b0, 20);
        for (int i = 1; i <= 3; i++) begin step(); drive(1, 8'h40 + 8'(i), 0); end
        step(); drive(0, 0, 1);
        chk("t5_count3", count, 3);
        step(); drive(0, 0, 0);
        chk("t5_flush_count", count, 0);
        chk("t5_flush_empty", empty, 1);
        l = n_launch;
        wait_sig("t5_frame_done", 1, 1'b1, 200);
        repeat (20) step();
        chk("t5_no_launch", n_launch, l);
        // reset during WAIT_DONE
        step(); drive(1, 8'h50, 0);
        step(); drive(1, 8'h51, 0);
        step(); drive(1, 8'h52, 0);
        step(); drive(0, 0, 0);
        wait_sig("t5_busy2", 1, 1'b0, 20);
        sys_rst_l = 1'b0;
        step();
        sys_rst_l = 1'b1;
        chk("t5_rst_count", count, 0);
        chk("t5_rst_empty", empty, 1);
        chk("t5_rst_xmitH", xmitH, 0);
        chk("t5_rst_data", xmit_dataH, 0);
        l = n_launch;
        wait_sig("t5_frame_done2", 1, 1'b1, 200);
        repeat (10) step();
        chk("t5_rst_no_launch", n_launch, l);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step();
            drive($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 199) == 0);
            frame_len = $urandom_range(3, 25);
        end
        step(); drive(0, 0, 0);
        drain(5000);
`ifdef UART_TXQ_STATS_EN
        sys_rst_l = 1'b0;
        step();
        sys_rst_l = 1'b1;
        chk("st_rst_sent", sent_cnt, 0);
        chk("st_rst_drop", drop_cnt, 0);
        frame_len = 8;
        for (int i = 0; i < 5; i++) begin step(); drive(1, 8'h60 + 8'(i), 0); end
        step(); drive(0, 0, 0);
        drain(500);
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); drive(1, 8'h70 + 8'(i), 0); end
        step(); drive(0, 0, 1);
        step(); drive(0, 0, 0);
        for (int i = 0; i < 17; i++) begin step(); drive(1, 8'h80 + 8'(i), 0); end
        step(); drive(0, 0, 0);
        repeat (3) step();
        chk("st_sent", sent_cnt, 5);
        chk("st_drop", drop_cnt, 4);
        chk("st_err", err_cnt, 0);
        drive(0, 0, 1);
        step(); drive(0, 0, 0);
        step();
        chk("st_drop_flush16", drop_cnt, 20);
        hold_busy = 1'b0;
        drain(200);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte FIFO and launch sequencer that sits directly upstream of the UART transmitter (u_xmit) and drives its xmitH / xmit_dataH inputs.
- Host logic writes bytes at any rate. The block pops one byte at a time and pulses xmitH only when the transmitter reports idle (xmit_doneH high).
- It then tracks the transmitter's busy/done cycle before launching the next byte, so frames go out back-to-back with no host polling.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- AW, 4, pointer width; must equal log2(DEPTH).
- BUSY_TMO, 7, cycles to wait for xmit_doneH to fall after a launch before flagging launch_err.

Ports:
- sys_clk  in  1  clock; all logic on its rising edge.
- sys_rst_l  in  1  reset; synchronous, active-low.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  8  byte to queue.
- flush  in  1  discard all queued (not yet launched) bytes.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AW+1  bytes queued.
- overflow  out  1  one-cycle pulse: wr_en while full and not popping.
- launch_err  out  1  one-cycle pulse: transmitter never went busy.
- xmitH  out  1  one-cycle launch pulse to transmitter.
- xmit_dataH  out  8  byte for transmitter; held stable between launches.
- xmit_doneH  in  1  transmitter idle/done level, registered inside the transmitter.

Behaviour:
- Reset (sys_rst_l low at a clock edge):
  - Pointers, count, FSM and all outputs cleared: full=0, empty=1, count=0, overflow=0, launch_err=0, xmitH=0, xmit_dataH=8'h00, state=IDLE.
  - Reset mid-frame drops the queue. The in-flight frame belongs to the transmitter and is not affected here.
- FIFO:
  - Circular buffer with AW-bit read/write pointers that wrap modulo DEPTH. count is maintained separately.
  - Write accepted when wr_en && (!full || pop).
  - Simultaneous push+pop: count unchanged; a push into a full FIFO in the same cycle as a pop succeeds.
  - Rejected write: data discarded, overflow=1 for one cycle.
  - full, empty and count are registered and reflect the state after the edge.
- flush:
  - Zeroes pointers and count on the next edge; takes priority over wr_en and pop in the same cycle.
  - Does not alter xmitH, xmit_dataH or the FSM.
- FSM (registered; pop occurs only in IDLE):
  - IDLE: if !empty && xmit_doneH && !flush, then pop the head, xmit_dataH <= head, xmitH <= 1, go to ARMED. Otherwise stay.
  - ARMED: xmitH <= 0, load timeout counter with BUSY_TMO, go to WAIT_BUSY.
  - WAIT_BUSY:
    - If xmit_doneH == 0, go to WAIT_DONE.
    - Else decrement the counter. At 0, launch_err=1 for one cycle and go to IDLE; the byte is considered lost.
  - WAIT_DONE: when xmit_doneH == 1, go to IDLE.
  - Illegal state encodings recover to IDLE.
- xmitH is high for exactly one cycle per popped byte, never two launches without an intervening xmit_doneH low phase (except the timeout path).
- Latency:
  - wr_en at cycle 0 into an empty queue with the transmitter idle: empty=0 at cycle 1, xmitH=1 at cycle 2.
  - After xmit_doneH re-rises at cycle N with data queued: state returns to IDLE at N+1, next xmitH at N+2.
- Arithmetic: count is AW+1 bits, range 0..DEPTH, no wrap.

Optional Feature:
- Macro UART_TXQ_STATS_EN.
- Defined:
  - Adds outputs sent_cnt[15:0], drop_cnt[15:0] and err_cnt[7:0], all reset to 0 and saturating at all-ones.
  - sent_cnt increments on each launch.
  - drop_cnt increments on each overflow pulse and, on flush, adds the discarded count (saturating).
  - err_cnt increments on each launch_err.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package uart_txq_pkg:
  - FSM state enum: IDLE=2'd0, ARMED=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3.
  - Byte width constant UART_BYTE_W=8.
  - Default DEPTH and BUSY_TMO.
- One natural sub-module, uart_txq_fifo: storage, pointers, count, full/empty, flush and overflow. The top module holds the FSM, launch register and optional stats.

Test Plan:
- Reset, then write 8'hA5 with a transmitter model holding xmit_doneH=1 and dropping it 2 cycles after xmitH -> empty falls at cycle 1, xmitH=1 only at cycle 2 with xmit_dataH=8'hA5, count returns to 0.
- Burst-write 8'h01..8'h05 back-to-back, model frame length 160 cycles -> exactly five xmitH pulses in order 01..05, each one 2 cycles after the previous xmit_doneH rise.
- Fill 16 bytes while the transmitter is busy, then write 8'hFF -> full=1, overflow pulses once, 8'hFF never transmitted. Same-cycle pop+push when full -> accepted with no overflow.
- Model never lowers xmit_doneH -> launch_err pulses 8 cycles after ARMED, FSM returns to IDLE, next byte launches.
- Queue 3 bytes mid-frame, assert flush -> count=0 next cycle, current frame completes, no further xmitH. sys_rst_l low mid-WAIT_DONE -> all outputs at reset values on the next edge.
- With UART_TXQ_STATS_EN: after 5 sends, 1 overflow and a flush of 3 -> sent_cnt=5, drop_cnt=4, err_cnt=0.
